// File: rtl/bomb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bomb_pkg
//  Description : Shared state encoding and 7-segment patterns for the
//                bomb-dismantlement game stages.
//  Revision    : 1.0 - initial release
// ============================================================================
package bomb_pkg;

    // Game-stage states shared by the display and entry stages
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ENTRY    = 3'd1,
        ST_CHECK    = 3'd2,
        ST_DEFUSED  = 3'd3,
        ST_EXPLODED = 3'd4
    } state_t;

    // Active-high segments: bit0=a ... bit6=g, bit7=dp
    localparam logic [7:0] SEG_DIGIT_0 = 8'b00111111;
    localparam logic [7:0] SEG_DIGIT_1 = 8'b00000110;
    localparam logic [7:0] SEG_DIGIT_2 = 8'b01011011;
    localparam logic [7:0] SEG_DIGIT_3 = 8'b01001111;
    localparam logic [7:0] SEG_DIGIT_4 = 8'b01100110;
    localparam logic [7:0] SEG_DIGIT_5 = 8'b01101101;
    localparam logic [7:0] SEG_DIGIT_6 = 8'b01111101;
    localparam logic [7:0] SEG_DIGIT_7 = 8'b00000111;
    localparam logic [7:0] SEG_DIGIT_8 = 8'b01111111;
    localparam logic [7:0] SEG_DIGIT_9 = 8'b01101111;

    localparam logic [7:0] SEG_D   = 8'b01011110;
    localparam logic [7:0] SEG_E   = 8'b01111001;
    localparam logic [7:0] SEG_OFF = 8'b00000000;

    // Decimal digit to segment pattern; out-of-range values blank the digit
    function automatic logic [7:0] seg_digit(input logic [3:0] d);
        logic [7:0] p;
        case (d)
            4'd0:    p = SEG_DIGIT_0;
            4'd1:    p = SEG_DIGIT_1;
            4'd2:    p = SEG_DIGIT_2;
            4'd3:    p = SEG_DIGIT_3;
            4'd4:    p = SEG_DIGIT_4;
            4'd5:    p = SEG_DIGIT_5;
            4'd6:    p = SEG_DIGIT_6;
            4'd7:    p = SEG_DIGIT_7;
            4'd8:    p = SEG_DIGIT_8;
            4'd9:    p = SEG_DIGIT_9;
            default: p = SEG_OFF;
        endcase
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/password_entry_if.sv
`default_nettype none
// ============================================================================
//  Module      : password_entry_if
//  Description : Player-side signal bundle of the password entry stage.
//                master = environment (display stage, switches, button),
//                slave  = password_entry.
//  Revision    : 1.0 - initial release
// ============================================================================
interface password_entry_if;
    logic       start;
    logic [6:0] psw;
    logic [6:0] sw;
    logic       confirm;
    logic [6:0] LD;
    logic [7:0] seg;
    logic [1:0] tries_left;
    logic       defused;
    logic       exploded;

    modport master (
        output start, psw, sw, confirm,
        input  LD, seg, tries_left, defused, exploded
    );

    modport slave (
        input  start, psw, sw, confirm,
        output LD, seg, tries_left, defused, exploded
    );
endinterface
`default_nettype wire

// File: rtl/password_entry_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tick_gen
//  Description : Free-running 0..TICK_DIV-1 counter with synchronous clear
//                and enable; o_tick is high for the cycle in which the
//                counter wraps.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int TICK_DIV = 220
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_clr,
    input  wire logic i_en,
    output logic      o_tick
);

    localparam int              c_cnt_w   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(TICK_DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;

    // Count while enabled, wrapping at TICK_DIV-1; clear has priority
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            if (r_cnt == c_cnt_max) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_tick = i_en && (r_cnt == c_cnt_max);

endmodule
`default_nettype wire

// File: rtl/password_entry.sv
`default_nettype none
// ============================================================================
//  Module      : password_entry
//  Description : Captures the shown password, runs a timed entry window,
//                checks player guesses and ends in DEFUSED or EXPLODED.
//  Revision    : 1.0 - initial release
// ============================================================================
import bomb_pkg::*;

module password_entry #(
    parameter int TICK_DIV      = 220,
    parameter int ENTRY_SECONDS = 9,
    parameter int MAX_TRIES     = 3
) (
    input  wire logic        clk,
    input  wire logic        rst,
    password_entry_if.slave  bus
);

    localparam logic [3:0] c_entry_secs = 4'(ENTRY_SECONDS);
    localparam logic [1:0] c_max_tries  = 2'(MAX_TRIES);

    state_t     r_state,   w_state_nxt;
    logic [6:0] r_psw_q,   w_psw_nxt;
    logic [6:0] r_guess,   w_guess_nxt;
    logic [3:0] r_seconds, w_seconds_nxt;
    logic [1:0] r_tries,   w_tries_nxt;
    logic       r_start_q;
    logic       r_confirm_q;

    logic       w_start_rise;
    logic       w_confirm_rise;
    logic       w_tick;
    logic       w_tick_clr;
    logic       w_tick_en;
    logic       w_timeout;
    logic       w_active;

    assign w_start_rise   = bus.start   & ~r_start_q;
    assign w_confirm_rise = bus.confirm & ~r_confirm_q;
    assign w_active       = (r_state == ST_ENTRY) || (r_state == ST_CHECK);
    assign w_tick_en      = w_active;
    // The tick that takes the last second away is the timeout
    assign w_timeout      = w_tick && (r_seconds == 4'd1);

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_tick_clr),
        .i_en   (w_tick_en),
        .o_tick (w_tick)
    );

    // State and datapath registers, plus input edge-detect history
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_psw_q     <= '0;
            r_guess     <= '0;
            r_seconds   <= '0;
            r_tries     <= '0;
            r_start_q   <= 1'b0;
            r_confirm_q <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_psw_q     <= w_psw_nxt;
            r_guess     <= w_guess_nxt;
            r_seconds   <= w_seconds_nxt;
            r_tries     <= w_tries_nxt;
            r_start_q   <= bus.start;
            r_confirm_q <= bus.confirm;
        end
    end

    // Next-state and datapath update; timeout beats a guess, a match beats timeout
    always_comb begin
        w_state_nxt   = r_state;
        w_psw_nxt     = r_psw_q;
        w_guess_nxt   = r_guess;
        w_seconds_nxt = r_seconds;
        w_tries_nxt   = r_tries;
        w_tick_clr    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_rise) begin
                    w_psw_nxt     = bus.psw;
                    w_seconds_nxt = c_entry_secs;
                    w_tries_nxt   = c_max_tries;
                    w_tick_clr    = 1'b1;
                    w_state_nxt   = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                if (w_tick) begin
                    w_seconds_nxt = r_seconds - 4'd1;
                end
                if (w_timeout) begin
                    w_state_nxt = ST_EXPLODED;
                end else if (w_confirm_rise) begin
                    w_guess_nxt = bus.sw;
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (w_tick) begin
                    w_seconds_nxt = r_seconds - 4'd1;
                end
                if (r_guess == r_psw_q) begin
                    w_state_nxt = ST_DEFUSED;
                end else begin
                    w_tries_nxt = r_tries - 2'd1;
                    if ((r_tries == 2'd1) || w_timeout) begin
                        w_state_nxt = ST_EXPLODED;
                    end else begin
                        w_state_nxt = ST_ENTRY;
                    end
                end
            end
            default: begin
                // DEFUSED / EXPLODED are terminal until reset
            end
        endcase
    end

    // Display decode from registered state only
    always_comb begin
        bus.seg = SEG_OFF;
        case (r_state)
            ST_ENTRY, ST_CHECK: bus.seg = seg_digit(r_seconds);
            ST_DEFUSED:         bus.seg = SEG_D;
            ST_EXPLODED:        bus.seg = SEG_E;
            default:            bus.seg = SEG_OFF;
        endcase
    end

    assign bus.LD         = w_active ? bus.sw : 7'd0;
    assign bus.tries_left = r_tries;
    assign bus.defused    = (r_state == ST_DEFUSED);
    assign bus.exploded   = (r_state == ST_EXPLODED);

endmodule
`default_nettype wire

// File: tb/tb_password_entry.sv
`default_nettype none
// ============================================================================
//  Module      : tb_password_entry
//  Description : Self-checking bench for password_entry with a cycle-level
//                reference model based on elapsed time since entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_password_entry;

    localparam int c_tick_div = 4;
    localparam int c_secs     = 3;
    localparam int c_tries    = 3;
    localparam logic [6:0] c_psw = 7'b1010011;

    localparam int M_IDLE = 0, M_ENTRY = 1, M_CHECK = 2, M_DEF = 3, M_EXP = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    password_entry_if bus();

    password_entry #(
        .TICK_DIV      (c_tick_div),
        .ENTRY_SECONDS (c_secs),
        .MAX_TRIES     (c_tries)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference digit table
    logic [7:0] m_digits [0:9] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                   8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    int n_checks = 0;
    int n_pass   = 0;

    // Model state
    int         m_state   = M_IDLE;
    int         m_elapsed = 0;
    int         m_tries   = 0;
    logic [6:0] m_psw     = '0;
    logic [6:0] m_guess   = '0;
    logic       m_start_prev = 1'b0;
    logic       m_conf_prev  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs now applied
    task automatic model_edge();
        logic rise_s, rise_c;
        rise_s = bus.start & ~m_start_prev;
        rise_c = bus.confirm & ~m_conf_prev;
        if (rst) begin
            m_state = M_IDLE; m_elapsed = 0; m_tries = 0;
            m_psw = '0; m_guess = '0;
            m_start_prev = 1'b0; m_conf_prev = 1'b0;
        end else begin
            case (m_state)
                M_IDLE: if (rise_s) begin
                    m_psw = bus.psw; m_tries = c_tries; m_elapsed = 0; m_state = M_ENTRY;
                end
                M_ENTRY: begin
                    m_elapsed++;
                    if (m_elapsed >= c_secs * c_tick_div) m_state = M_EXP;
                    else if (rise_c) begin
                        m_guess = bus.sw; m_state = M_CHECK;
                    end
                end
                M_CHECK: begin
                    m_elapsed++;
                    if (m_guess == m_psw) m_state = M_DEF;
                    else begin
                        m_tries--;
                        if (m_tries == 0 || m_elapsed >= c_secs * c_tick_div) m_state = M_EXP;
                        else m_state = M_ENTRY;
                    end
                end
                default: ;
            endcase
            m_start_prev = bus.start;
            m_conf_prev  = bus.confirm;
        end
    endtask

    task automatic compare_all();
        logic [7:0] e_seg;
        logic [6:0] e_ld;
        int secs;
        secs  = c_secs - m_elapsed / c_tick_div;
        e_seg = 8'h00;
        e_ld  = 7'd0;
        if (m_state == M_ENTRY || m_state == M_CHECK) begin
            e_seg = m_digits[secs];
            e_ld  = bus.sw;
        end else if (m_state == M_DEF) begin
            e_seg = 8'b01011110;
        end else if (m_state == M_EXP) begin
            e_seg = 8'b01111001;
        end
        chk("seg",        {24'd0, bus.seg},        {24'd0, e_seg});
        chk("LD",         {25'd0, bus.LD},         {25'd0, e_ld});
        chk("tries_left", {30'd0, bus.tries_left}, 32'(m_tries));
        chk("defused",    {31'd0, bus.defused},    {31'd0, (m_state == M_DEF)});
        chk("exploded",   {31'd0, bus.exploded},   {31'd0, (m_state == M_EXP)});
    endtask

    // One clock: model sees the edge, outputs compared on the falling edge
    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.start = 1'b0; bus.confirm = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        bus.start = 1'b0; bus.confirm = 1'b0; bus.psw = c_psw; bus.sw = 7'd0;

        // Reset state
        cyc(); cyc();
        chk("reset_seg",   {24'd0, bus.seg}, 32'h0);
        chk("reset_tries", {30'd0, bus.tries_left}, 32'd0);
        rst = 1'b0;
        cyc();

        // Correct guess: confirm rise two cycles after start
        bus.start = 1'b1; cyc();
        bus.sw = c_psw;   cyc();
        bus.confirm = 1'b1; cyc();
        cyc();
        chk("ok_defused", {31'd0, bus.defused}, 32'd1);
        chk("ok_seg",     {24'd0, bus.seg}, 32'h5E);
        chk("ok_tries",   {30'd0, bus.tries_left}, 32'd3);
        do_reset();

        // Two wrong guesses, then correct
        bus.start = 1'b1; cyc();
        bus.sw = 7'd0;
        bus.confirm = 1'b1; cyc(); bus.confirm = 1'b0; cyc();
        chk("ww_tries2", {30'd0, bus.tries_left}, 32'd2);
        bus.confirm = 1'b1; cyc(); bus.confirm = 1'b0; cyc();
        chk("ww_tries1", {30'd0, bus.tries_left}, 32'd1);
        chk("ww_seg2",   {24'd0, bus.seg}, 32'h5B);
        bus.sw = c_psw;
        bus.confirm = 1'b1; cyc(); bus.confirm = 1'b0; cyc();
        chk("ww_defused", {31'd0, bus.defused}, 32'd1);
        do_reset();

        // Three wrong guesses
        bus.start = 1'b1; cyc();
        bus.sw = 7'd0;
        repeat (3) begin
            bus.confirm = 1'b1; cyc(); bus.confirm = 1'b0; cyc();
        end
        chk("www_exploded", {31'd0, bus.exploded}, 32'd1);
        chk("www_seg",      {24'd0, bus.seg}, 32'h79);
        chk("www_tries",    {30'd0, bus.tries_left}, 32'd0);
        do_reset();

        // No confirm: timeout after ENTRY_SECONDS*TICK_DIV cycles
        bus.start = 1'b1; cyc();
        k = 0;
        while (bus.exploded !== 1'b1 && k < 20) begin
            cyc(); k++;
        end
        chk("timeout_cycles", 32'(k), 32'd12);
        do_reset();

        // Confirm rise on the final tick: timeout wins
        bus.start = 1'b1; cyc();
        repeat (11) cyc();
        bus.sw = c_psw; bus.confirm = 1'b1; cyc();
        chk("tie_exploded", {31'd0, bus.exploded}, 32'd1);
        chk("tie_defused",  {31'd0, bus.defused},  32'd0);
        bus.confirm = 1'b0;
        do_reset();

        // start re-pulse during ENTRY is ignored
        bus.start = 1'b1; cyc();
        bus.start = 1'b0; cyc();
        bus.start = 1'b1; cyc();
        chk("repulse_seg",   {24'd0, bus.seg}, 32'h4F);
        chk("repulse_tries", {30'd0, bus.tries_left}, 32'd3);

        // Reset mid-ENTRY with start held: re-arm the cycle after reset drops
        cyc();
        rst = 1'b1; cyc();
        chk("rst_seg",   {24'd0, bus.seg}, 32'h0);
        chk("rst_tries", {30'd0, bus.tries_left}, 32'd0);
        rst = 1'b0; cyc();
        chk("rearm_seg",   {24'd0, bus.seg}, 32'h4F);
        chk("rearm_tries", {30'd0, bus.tries_left}, 32'd3);
        do_reset();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst         = ($urandom_range(0, 59) == 0);
            bus.start   = ($urandom_range(0, 1) == 1);
            bus.confirm = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 15) == 0) bus.psw = 7'($urandom);
            bus.sw = ($urandom_range(0, 2) == 0) ? m_psw : 7'($urandom);
            cyc();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
